gated_clock_bank: RTL and testbench
===================================

# gated_clock_bank

Multi-channel successor to the single-bit enabled flip-flop: a bank of `CHANNELS` registers, each `WIDTH` bits wide with its own capture enable. It adds an activity monitor FSM that shuts off a downstream clock-gate enable after a run of idle cycles. It then stalls new writes through a ready handshake while the gated domain wakes up. The block sits between request sources and a gated register domain, and it drives the enable pin of an external integrated clock-gating (ICG) cell.

## Interface
- `WIDTH`, 8, data width per channel (≥1)
- `CHANNELS`, 4, number of independent channels (≥1)
- `IDLE_CYCLES`, 8, consecutive idle ACTIVE cycles before gating (≥1)
- `WAKE_CYCLES`, 2, cycles spent in WAKE before writes are accepted (≥1)

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge
- `reset_in`  in  1  synchronous, active-high reset
- `d_in`  in  CHANNELS*WIDTH  write data; channel i is bits [i*WIDTH +: WIDTH]
- `enable_in`  in  CHANNELS  per-channel write request; the source holds the request and data until accepted
- `ready_out`  out  1  high when writes are accepted this cycle
- `q_out`  out  CHANNELS*WIDTH  registered channel contents
- `valid_out`  out  CHANNELS  one-cycle strobe, high in the cycle after channel i captured
- `gate_en_out`  out  1  enable for the external ICG; 0 means the downstream clock is gated
- `gated_out`  out  1  status, high while the FSM is in GATED

## Operation
- One clock, `clk`. Reset is synchronous and active-high on `reset_in`; there is no asynchronous reset.
- The FSM has three states: ACTIVE, GATED and WAKE. All outputs are Moore outputs, decoded from state or registered.
  - ACTIVE: `ready_out`=1, `gate_en_out`=1, `gated_out`=0.
  - GATED: `ready_out`=0, `gate_en_out`=0, `gated_out`=1.
  - WAKE: `ready_out`=0, `gate_en_out`=1, `gated_out`=0.
- Capture rule: on the rising edge where `enable_in[i] && ready_out`, `q_out[i]` takes `d_in[i]` and `valid_out[i]` is 1 for the next cycle only. Channels are independent, so any subset can capture on the same edge. Channels that do not capture hold their value.
- Idle counter (ACTIVE only):
  - Width is `$clog2(IDLE_CYCLES+1)`.
  - A cycle with `enable_in`==0 increments the counter.
  - A cycle with any enable bit set clears it to 0.
- ACTIVE→GATED: on the edge where `enable_in`==0 and the idle counter equals `IDLE_CYCLES-1`.
- GATED→WAKE: on the first edge with `enable_in`≠0. The wake counter clears to 0.
- WAKE→ACTIVE: on the edge where the wake counter equals `WAKE_CYCLES-1`. Otherwise the wake counter increments. On entry to ACTIVE the idle counter is 0.
- WAKE completes even if `enable_in` drops to 0 during WAKE. The block then enters ACTIVE and begins counting idle from 0.
- Registers hold their values in GATED and WAKE. `enable_in` is never captured while `ready_out`=0.
- Simultaneous events: an enable arriving in the ACTIVE cycle where the idle counter equals `IDLE_CYCLES-1` is captured, the counter clears, and the FSM does not gate.
- Reset values: state ACTIVE, both counters 0, `q_out`=0, `valid_out`=0, `ready_out`=1, `gate_en_out`=1, `gated_out`=0.
- Reset in any state (including mid-WAKE or in GATED) returns to these values on the next edge, and reset overrides capture on that edge.

## Timing
- Capture latency: `q_out` and `valid_out` update 1 cycle after the accepting edge.
- Gating: with reset released before cycle 0 and no enables, cycles 0..`IDLE_CYCLES`-1 are ACTIVE and cycle `IDLE_CYCLES` is GATED.
- Wake: with GATED in cycle t and `enable_in`≠0 in cycle t:
  - `gate_en_out` rises in cycle t+1.
  - WAKE occupies cycles t+1..t+`WAKE_CYCLES`.
  - `ready_out` rises in cycle t+`WAKE_CYCLES`+1, and capture happens on that cycle's edge.
  - A held request therefore sees a latency of `WAKE_CYCLES`+1 cycles to acceptance and `WAKE_CYCLES`+2 cycles to `q_out`.
- `gate_en_out` is registered and glitch-free. It changes only on the rising edge of `clk`, so it is safe at the input of a latch-based ICG.

## Test plan
All scenarios use WIDTH=8, CHANNELS=4, IDLE_CYCLES=8, WAKE_CYCLES=2.
- Reset check: assert `reset_in` for 2 cycles → `q_out`=0, `valid_out`=0, `ready_out`=1, `gate_en_out`=1, `gated_out`=0.
- Per-channel capture: in ACTIVE drive `enable_in`=4'b0101 with `d_in`=32'hDD_CC_BB_AA → next cycle ch0=8'hAA and ch2=8'hCC, ch1 and ch3 unchanged, `valid_out`=4'b0101 for exactly 1 cycle.
- Idle gating: after the last capture apply 8 idle cycles → `gated_out`=1 and `gate_en_out`=0 on the 9th cycle. Repeat with a single enable on idle cycle 8 → no gating, data captured.
- Wake handshake: in GATED hold `enable_in`=4'b1000 with ch3 data 8'h5A → `gate_en_out`=1 after 1 cycle, `ready_out`=1 after 3 cycles, ch3=8'h5A after 4 cycles. `q_out` stays unchanged during WAKE.
- Wake abort: raise `enable_in` for 1 cycle in GATED, then drop it → WAKE still completes into ACTIVE with no capture, then gates again 8 idle cycles later.
- Reset mid-WAKE: assert `reset_in` in the first WAKE cycle → the next cycle is ACTIVE with `q_out`=0 and `ready_out`=1.

Source files
------------

// File: rtl/gated_clock_bank.sv
// Bank of per-channel enabled registers with an activity monitor that drives the
// enable of an external clock-gating cell and stalls writes while the gated domain wakes.
module gated_clock_bank #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned IDLE_CYCLES = 8,
    parameter int unsigned WAKE_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      reset_in,
    input  logic [CHANNELS*WIDTH-1:0] d_in,
    input  logic [CHANNELS-1:0]       enable_in,
    output logic                      ready_out,
    output logic [CHANNELS*WIDTH-1:0] q_out,
    output logic [CHANNELS-1:0]       valid_out,
    output logic                      gate_en_out,
    output logic                      gated_out
);

    localparam int unsigned IDLE_W = $clog2(IDLE_CYCLES + 1);
    localparam int unsigned WAKE_W = $clog2(WAKE_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
    localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_ACTIVE,
        ST_GATED,
        ST_WAKE
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [IDLE_W-1:0]   idle_cnt;
    logic [IDLE_W-1:0]   idle_nx;
    logic [WAKE_W-1:0]   wake_cnt;
    logic [WAKE_W-1:0]   wake_nx;
    logic                any_req;
    logic [CHANNELS-1:0] accept;

    assign any_req = |enable_in;
    assign accept  = enable_in & {CHANNELS{ready_out}};

    always_comb begin
        state_nx = state;
        idle_nx  = idle_cnt;
        wake_nx  = wake_cnt;
        case (state)
            ST_ACTIVE: begin
                if (any_req) begin
                    idle_nx = '0;
                end else if (idle_cnt == IDLE_LAST) begin
                    state_nx = ST_GATED;
                    idle_nx  = '0;
                end else begin
                    idle_nx = idle_cnt + 1'b1;
                end
            end
            ST_GATED: begin
                if (any_req) begin
                    state_nx = ST_WAKE;
                    wake_nx  = '0;
                end
            end
            ST_WAKE: begin
                // Wake runs to completion even if the request is withdrawn.
                if (wake_cnt == WAKE_LAST) begin
                    state_nx = ST_ACTIVE;
                    idle_nx  = '0;
                    wake_nx  = '0;
                end else begin
                    wake_nx = wake_cnt + 1'b1;
                end
            end
            default: begin
                state_nx = ST_ACTIVE;
                idle_nx  = '0;
                wake_nx  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_in) begin
            state    <= ST_ACTIVE;
            idle_cnt <= '0;
            wake_cnt <= '0;
        end else begin
            state    <= state_nx;
            idle_cnt <= idle_nx;
            wake_cnt <= wake_nx;
        end
    end

    // Status outputs are registered from the next state so the ICG enable never glitches.
    always_ff @(posedge clk) begin
        if (reset_in) begin
            ready_out   <= 1'b1;
            gate_en_out <= 1'b1;
            gated_out   <= 1'b0;
        end else begin
            ready_out   <= (state_nx == ST_ACTIVE);
            gate_en_out <= (state_nx != ST_GATED);
            gated_out   <= (state_nx == ST_GATED);
        end
    end

    always_ff @(posedge clk) begin
        if (reset_in) begin
            q_out     <= '0;
            valid_out <= '0;
        end else begin
            valid_out <= accept;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (accept[i]) begin
                    q_out[i*WIDTH +: WIDTH] <= d_in[i*WIDTH +: WIDTH];
                end
            end
        end
    end

endmodule

// File: tb/tb_gated_clock_bank.sv
// Directed plus randomized bench for gated_clock_bank, checked against a
// behavioural model of gating, wake-up and per-channel capture.
module tb_gated_clock_bank;

    localparam int unsigned W    = 8;
    localparam int unsigned CH   = 4;
    localparam int unsigned IDLE = 8;
    localparam int unsigned WAKE = 2;

    logic              clk = 1'b0;
    logic              reset_in;
    logic [CH*W-1:0]   d_in;
    logic [CH-1:0]     enable_in;
    logic              ready_out;
    logic [CH*W-1:0]   q_out;
    logic [CH-1:0]     valid_out;
    logic              gate_en_out;
    logic              gated_out;

    int checks = 0;
    int errors = 0;

    // Model: gated flag, remaining wake cycles, length of the current idle run.
    logic [W-1:0]  m_q [CH];
    logic [CH-1:0] m_valid;
    bit            m_gated;
    int            m_wake_left;
    int            m_idle_run;

    gated_clock_bank #(
        .WIDTH(W),
        .CHANNELS(CH),
        .IDLE_CYCLES(IDLE),
        .WAKE_CYCLES(WAKE)
    ) dut (
        .clk(clk),
        .reset_in(reset_in),
        .d_in(d_in),
        .enable_in(enable_in),
        .ready_out(ready_out),
        .q_out(q_out),
        .valid_out(valid_out),
        .gate_en_out(gate_en_out),
        .gated_out(gated_out)
    );

    always #5 clk = ~clk;

    function automatic logic [CH*W-1:0] m_qvec();
        logic [CH*W-1:0] v;
        for (int i = 0; i < CH; i++) v[i*W +: W] = m_q[i];
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit rdy;
        if (reset_in) begin
            for (int i = 0; i < CH; i++) m_q[i] = '0;
            m_valid     = '0;
            m_gated     = 0;
            m_wake_left = 0;
            m_idle_run  = 0;
        end else begin
            rdy     = !m_gated && (m_wake_left == 0);
            m_valid = rdy ? enable_in : '0;
            for (int i = 0; i < CH; i++)
                if (rdy && enable_in[i]) m_q[i] = d_in[i*W +: W];
            if (m_gated) begin
                if (enable_in != 0) begin
                    m_gated     = 0;
                    m_wake_left = WAKE;
                end
            end else if (m_wake_left > 0) begin
                m_wake_left--;
                if (m_wake_left == 0) m_idle_run = 0;
            end else if (enable_in != 0) begin
                m_idle_run = 0;
            end else begin
                m_idle_run++;
                if (m_idle_run == IDLE) begin
                    m_gated    = 1;
                    m_idle_run = 0;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("q", q_out, m_qvec());
        chk("valid", valid_out, m_valid);
        chk("ready", ready_out, !m_gated && (m_wake_left == 0));
        chk("gate_en", gate_en_out, !m_gated);
        chk("gated", gated_out, m_gated);
    endtask

    initial begin
        reset_in  = 1'b1;
        enable_in = '0;
        d_in      = '0;
        step();
        step();
        chk("rst_q", q_out, 0);
        chk("rst_valid", valid_out, 0);
        chk("rst_ready", ready_out, 1);
        chk("rst_gate_en", gate_en_out, 1);
        chk("rst_gated", gated_out, 0);
        reset_in = 1'b0;

        // Per-channel capture
        enable_in = 4'b0101;
        d_in      = 32'hDDCC_BBAA;
        step();
        chk("cap_q", q_out, 32'h00CC_00AA);
        chk("cap_valid", valid_out, 4'b0101);
        enable_in = '0;
        step();
        chk("cap_valid_once", valid_out, 0);

        // Idle gating: eight idle edges after the capture
        repeat (6) step();
        chk("idle7_not_gated", gated_out, 0);
        step();
        chk("idle8_gated", gated_out, 1);
        chk("idle8_gate_en", gate_en_out, 0);

        // Wake handshake with held request on ch3
        enable_in = 4'b1000;
        d_in      = 32'h5A00_0000;
        step();
        chk("wake_gate_en", gate_en_out, 1);
        chk("wake_ready0", ready_out, 0);
        step();
        chk("wake_q_hold", q_out, 32'h00CC_00AA);
        step();
        chk("wake_ready1", ready_out, 1);
        chk("wake_q_hold2", q_out, 32'h00CC_00AA);
        step();
        chk("wake_cap_q", q_out, 32'h5ACC_00AA);
        chk("wake_cap_valid", valid_out, 4'b1000);
        enable_in = '0;

        // Enable on the last idle cycle prevents gating
        repeat (7) step();
        enable_in = 4'b0010;
        d_in      = 32'h0000_7700;
        step();
        chk("late_en_not_gated", gated_out, 0);
        chk("late_en_q", q_out, 32'h5ACC_77AA);
        enable_in = '0;

        // Wake abort: one-cycle request, wake still completes without capture
        repeat (8) step();
        chk("abort_gated", gated_out, 1);
        enable_in = 4'b0001;
        d_in      = 32'h0000_00EE;
        step();
        enable_in = '0;
        step();
        step();
        chk("abort_ready", ready_out, 1);
        chk("abort_q", q_out, 32'h5ACC_77AA);
        chk("abort_valid", valid_out, 0);
        repeat (7) step();
        chk("abort_idle7", gated_out, 0);
        step();
        chk("abort_regate", gated_out, 1);

        // Reset during the first WAKE cycle
        enable_in = 4'b0010;
        step();
        chk("midwake_in_wake", ready_out, 0);
        reset_in  = 1'b1;
        enable_in = '0;
        step();
        chk("midwake_rst_ready", ready_out, 1);
        chk("midwake_rst_q", q_out, 0);
        chk("midwake_rst_gate_en", gate_en_out, 1);
        reset_in = 1'b0;

        // Randomized traffic alternating quiet and busy phases
        for (int c = 0; c < 1500; c++) begin
            reset_in = ($urandom_range(0, 99) == 0);
            if ((c % 200) < 100)
                enable_in = ($urandom_range(0, 9) == 0) ? CH'($urandom) : '0;
            else
                enable_in = ($urandom_range(0, 1) == 0) ? CH'($urandom) : '0;
            d_in = $urandom;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
